// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, core redirect,
// and the decode-side output handshake.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );

  // Memory / core / decode side
  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, a 2-entry
// in-order {inst, pc} buffer toward decode, and redirect/flush handling.
// A request is only launched when the buffer will have room for its data,
// so a push never lands in a full buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic         clk,
  input  logic         rstn,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no request outstanding
    REQ    = 2'd1,  // request outstanding, response will be kept
    SQUASH = 2'd2   // request outstanding, response will be dropped
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0][31:0]  inst_q, inst_d;
  logic [1:0][31:0]  epc_q, epc_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              pop;
  logic              push;
  logic [1:0]        cnt_pop;
  logic [1:0]        cnt_post;
  logic [31:0]       tgt_pc;

  // Buffer occupancy bookkeeping; a redirect overrides any pop or push.
  always_comb begin
    pop      = (cnt_q != 2'd0) && bus.out_ready && !bus.redirect;
    push     = (state_q == REQ) && bus.imem_ack && !bus.redirect;
    cnt_pop  = cnt_q - {1'b0, pop};
    cnt_post = cnt_pop + {1'b0, push};
    tgt_pc   = {bus.redirect_pc[31:2], 2'b00};
  end

  // Next-state, fetch PC and request address.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (bus.redirect) begin
      pc_d = tgt_pc;
      unique case (state_q)
        IDLE: begin
          state_d = REQ;
          addr_d  = tgt_pc;
        end
        REQ, SQUASH: begin
          if (bus.imem_ack) begin
            // Old response dies here; the new target goes out immediately.
            state_d = REQ;
            addr_d  = tgt_pc;
          end else begin
            // Address must hold until the old request completes.
            state_d = SQUASH;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_pop < 2'd2) begin
            state_d = REQ;
            addr_d  = pc_q;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            pc_d = addr_q + 32'd4;
            if (cnt_post < 2'd2) begin
              addr_d = addr_q + 32'd4;
            end else begin
              state_d = IDLE;
            end
          end
        end
        SQUASH: begin
          if (bus.imem_ack) begin
            state_d = REQ;
            addr_d  = pc_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Buffer storage and pointers; a redirect empties it.
  always_comb begin
    inst_d   = inst_q;
    epc_d    = epc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (bus.redirect) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        inst_d[wr_ptr_q] = bus.imem_rdata;
        epc_d[wr_ptr_q]  = addr_q;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_post;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      inst_q   <= '0;
      epc_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      epc_q    <= epc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.imem_req  = (state_q != IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_inst  = inst_q[rd_ptr_q];
  assign bus.out_pc    = epc_q[rd_ptr_q];

endmodule
